// File: rtl/vrased_rst_ctrl_if.sv
// rtl/vrased_rst_ctrl_if.sv - monitor kill inputs and reset/cause outputs of the VRASED reset controller
interface vrased_rst_ctrl_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0] viol_in;
    logic               cause_clr;
    logic               sys_rst;
    logic [NUM_SRC-1:0] cause;
    logic               cause_valid;
    logic [7:0]         evt_cnt;
    logic               busy;

    modport master (
        output viol_in, cause_clr,
        input  sys_rst, cause, cause_valid, evt_cnt, busy
    );

    modport slave (
        input  viol_in, cause_clr,
        output sys_rst, cause, cause_valid, evt_cnt, busy
    );
endinterface

// File: rtl/vrased_rst_ctrl.sv
// rtl/vrased_rst_ctrl.sv - folds monitor kill levels into a stretched core reset with sticky cause and event count
module vrased_rst_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int STRETCH = 16,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    vrased_rst_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        WAIT_CLR = 2'd2
    } state_t;

    localparam logic [7:0] STRETCH_M1 = 8'(STRETCH - 1);
    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         wcnt_q, wcnt_d;
    logic [NUM_SRC-1:0] cause_q, cause_d;
    logic               cause_valid_q, cause_valid_d;
    logic [7:0]         evt_cnt_q, evt_cnt_d;
    logic               sys_rst_q, sys_rst_d;
    logic               busy_q, busy_d;
    logic [7:0]         evt_inc;

    assign evt_inc = (evt_cnt_q == 8'hFF) ? 8'hFF : evt_cnt_q + 8'd1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wcnt_d        = wcnt_q;
        cause_d       = cause_q;
        cause_valid_d = cause_valid_q;
        evt_cnt_d     = evt_cnt_q;
        case (state_q)
            IDLE: begin
                if (|bus.viol_in) begin
                    state_d       = ASSERT;
                    cnt_d         = STRETCH_M1;
                    // A clear arriving with a new violation drops only the stale bits.
                    cause_d       = bus.cause_clr ? bus.viol_in : (cause_q | bus.viol_in);
                    cause_valid_d = 1'b1;
                    evt_cnt_d     = evt_inc;
                end else if (bus.cause_clr) begin
                    cause_d       = '0;
                    cause_valid_d = 1'b0;
                end
            end
            ASSERT: begin
                cause_d = cause_q | bus.viol_in;
                if (cnt_q == 8'd0) begin
                    state_d = WAIT_CLR;
                    wcnt_d  = TIMEOUT_M1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            WAIT_CLR: begin
                cause_d = cause_q | bus.viol_in;
                if (bus.viol_in == '0) begin
                    state_d = IDLE;
                end else if (wcnt_q == 8'd0) begin
                    state_d   = ASSERT;
                    cnt_d     = STRETCH_M1;
                    evt_cnt_d = evt_inc;
                end else begin
                    wcnt_d = wcnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        sys_rst_d = (state_d == ASSERT);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            wcnt_q        <= 8'd0;
            cause_q       <= '0;
            cause_valid_q <= 1'b0;
            evt_cnt_q     <= 8'd0;
            sys_rst_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wcnt_q        <= wcnt_d;
            cause_q       <= cause_d;
            cause_valid_q <= cause_valid_d;
            evt_cnt_q     <= evt_cnt_d;
            sys_rst_q     <= sys_rst_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.sys_rst     = sys_rst_q;
    assign bus.busy        = busy_q;
    assign bus.cause       = cause_q;
    assign bus.cause_valid = cause_valid_q;
    assign bus.evt_cnt     = evt_cnt_q;
endmodule

// File: tb/tb_vrased_rst_ctrl.sv
// tb/tb_vrased_rst_ctrl.sv - randomized and directed self-checking bench for vrased_rst_ctrl
module tb_vrased_rst_ctrl;
    localparam int NSRC = 4;
    localparam int STR  = 4;
    localparam int TMO  = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vrased_rst_ctrl_if #(.NUM_SRC(NSRC)) bus ();

    vrased_rst_ctrl #(.NUM_SRC(NSRC), .STRETCH(STR), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Reference: cycles of pulse left, and how long we have lingered after a pulse.
    int       m_pulse_left = 0;
    bit       m_waiting = 1'b0;
    int       m_wait_elapsed = 0;
    bit [3:0] m_cause = '0;
    bit       m_valid = 1'b0;
    int       m_evt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start_pulse();
        m_pulse_left = STR;
        m_waiting    = 1'b0;
        m_evt        = (m_evt >= 255) ? 255 : m_evt + 1;
    endtask

    task automatic cyc(input logic [3:0] v, input logic clr, input logic rn);
        bus.viol_in   = v;
        bus.cause_clr = clr;
        reset_n       = rn;
        @(posedge clk);
        if (!rn) begin
            m_pulse_left = 0; m_waiting = 0; m_wait_elapsed = 0;
            m_cause = '0; m_valid = 0; m_evt = 0;
        end else if (m_pulse_left > 0) begin
            m_cause = m_cause | v;
            m_pulse_left--;
            if (m_pulse_left == 0) begin
                m_waiting = 1'b1;
                m_wait_elapsed = 0;
            end
        end else if (m_waiting) begin
            m_cause = m_cause | v;
            if (v == 4'd0) m_waiting = 1'b0;
            else if (m_wait_elapsed == TMO - 1) start_pulse();
            else m_wait_elapsed++;
        end else if (v != 4'd0) begin
            m_cause = clr ? v : (m_cause | v);
            m_valid = 1'b1;
            start_pulse();
        end else if (clr) begin
            m_cause = '0;
            m_valid = 1'b0;
        end
        chk_en = 1'b1;
        #2;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sys_rst",     32'(bus.sys_rst),     32'(m_pulse_left > 0));
            chk("busy",        32'(bus.busy),        32'((m_pulse_left > 0) || m_waiting));
            chk("cause",       32'(bus.cause),       32'(m_cause));
            chk("cause_valid", 32'(bus.cause_valid), 32'(m_valid));
            chk("evt_cnt",     32'(bus.evt_cnt),     32'(m_evt));
        end
    end

    initial begin
        int hc, last_sr, last_b, rises, highs;
        logic prev;
        logic [3:0] rv;

        bus.viol_in = 4'hF;
        bus.cause_clr = 1'b0;

        // 1: reset defaults, then first sampling edge raises sys_rst
        repeat (3) cyc(4'hF, 1'b0, 1'b0);
        chk("rst_sys_rst", 32'(bus.sys_rst), 32'd0);
        chk("rst_evt_cnt", 32'(bus.evt_cnt), 32'd0);
        chk("rst_cause", 32'(bus.cause), 32'd0);
        cyc(4'hF, 1'b0, 1'b1);
        chk("t1_sys_rst", 32'(bus.sys_rst), 32'd1);
        chk("t1_evt", 32'(bus.evt_cnt), 32'd1);
        repeat (8) cyc(4'h0, 1'b0, 1'b1);
        cyc(4'h0, 1'b1, 1'b1);
        chk("t1_clr_cause", 32'(bus.cause), 32'd0);

        // 2: single event width and busy trailing
        cyc(4'b0010, 1'b0, 1'b1);
        hc = int'(bus.sys_rst); last_sr = -1; last_b = -1;
        for (int i = 0; i < 10; i++) begin
            cyc(4'h0, 1'b0, 1'b1);
            if (bus.sys_rst) begin hc++; last_sr = i; end
            if (bus.busy) last_b = i;
        end
        chk("t2_width", 32'(hc), 32'd4);
        chk("t2_busy_tail", 32'(last_b - last_sr), 32'd1);
        chk("t2_cause", 32'(bus.cause), 32'h2);
        chk("t2_evt", 32'(bus.evt_cnt), 32'd2);

        // 3: accumulating cause within one pulse
        cyc(4'h0, 1'b1, 1'b1);
        cyc(4'b0001, 1'b0, 1'b1);
        cyc(4'b0000, 1'b0, 1'b1);
        cyc(4'b0100, 1'b0, 1'b1);
        repeat (8) cyc(4'h0, 1'b0, 1'b1);
        chk("t3_cause", 32'(bus.cause), 32'h5);
        chk("t3_evt", 32'(bus.evt_cnt), 32'd3);

        // 4: timeout re-assertion with a held violation
        cyc(4'h0, 1'b1, 1'b1);
        prev = 1'b0; rises = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(4'b1000, 1'b0, 1'b1);
            if (bus.sys_rst && !prev) rises++;
            prev = bus.sys_rst;
        end
        chk("t4_rises", 32'(rises), 32'd3);
        chk("t4_evt", 32'(bus.evt_cnt), 32'd6);
        cyc(4'h0, 1'b0, 1'b1);
        chk("t4_idle", 32'(bus.busy), 32'd0);
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(4'h0, 1'b0, 1'b1);
            if (bus.sys_rst) highs++;
        end
        chk("t4_no_pulse", 32'(highs), 32'd0);

        // 5: cause_clr rules
        cyc(4'h0, 1'b1, 1'b1);
        cyc(4'b0001, 1'b0, 1'b1);
        cyc(4'b0000, 1'b1, 1'b1);
        chk("t5_clr_in_assert", 32'({bus.cause_valid, bus.cause}), 32'h11);
        repeat (8) cyc(4'h0, 1'b0, 1'b1);
        cyc(4'b0100, 1'b1, 1'b1);
        chk("t5_clr_with_viol", 32'({bus.cause_valid, bus.cause}), 32'h14);
        chk("t5_evt", 32'(bus.evt_cnt), 32'd8);
        repeat (8) cyc(4'h0, 1'b0, 1'b1);
        cyc(4'h0, 1'b1, 1'b1);
        chk("t5_clr_idle", 32'({bus.cause_valid, bus.cause}), 32'h00);

        // random traffic against the model
        rv = 4'h0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0)
                rv = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            cyc(rv, 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 99) != 0));
        end
        repeat (12) cyc(4'h0, 1'b0, 1'b1);

        // 6: saturation, then reset in the middle of a pulse
        for (int i = 0; i < 256; i++) begin
            cyc(4'($urandom_range(1, 15)), 1'b0, 1'b1);
            repeat (6) cyc(4'h0, 1'($urandom_range(0, 1)), 1'b1);
        end
        chk("t6_sat", 32'(bus.evt_cnt), 32'd255);
        cyc(4'b0001, 1'b0, 1'b1);
        chk("t6_sat_pulse", 32'({bus.sys_rst, bus.evt_cnt}), 32'h1FF);
        cyc(4'h0, 1'b0, 1'b1);
        chk("t6_second_cycle", 32'(bus.sys_rst), 32'd1);
        cyc(4'h0, 1'b0, 1'b0);
        chk("t6_rst_sys_rst", 32'(bus.sys_rst), 32'd0);
        chk("t6_rst_evt", 32'(bus.evt_cnt), 32'd0);
        repeat (3) cyc(4'h0, 1'b0, 1'b1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
